// File: rtl/mp64_sram_arb_pkg.sv
// mp64_sram_arb_pkg: requester ids, read-tag type and latency helper for mp64_sram_arb.
package mp64_sram_arb_pkg;
    typedef enum logic {REQ0 = 1'b0, REQ1 = 1'b1} req_id_e;
    typedef struct packed {
        logic    valid;
        req_id_e id;
    } tag_t;
    function automatic int arb_lat(input int out_reg);
        return 1 + out_reg;
    endfunction
endpackage

// File: rtl/mp64_rr_arb2.sv
// mp64_rr_arb2: two-way one-hot grant; round-robin when MP64_SRAM_ARB_RR_EN is defined,
// otherwise fixed priority with requester 0 highest.
module mp64_rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] valid,
    input  logic       advance,
    output logic [1:0] grant
);
`ifdef MP64_SRAM_ARB_RR_EN
    logic ptr_q;
    // The pointer names the preferred requester; after a grant it points at the loser.
    always_ff @(posedge clk) begin
        if (!rst_n) ptr_q <= 1'b0;
        else if (advance) ptr_q <= grant[0];
    end
    assign grant[0] = valid[0] & (~valid[1] | ~ptr_q);
    assign grant[1] = valid[1] & (~valid[0] | ptr_q);
`else
    logic unused_pins;
    assign unused_pins = ^{clk, rst_n, advance};
    assign grant = {valid[1] & ~valid[0], valid[0]};
`endif
endmodule

// File: rtl/mp64_sram_arb.sv
// mp64_sram_arb: shares one single-port SRAM between two masters and routes read data back.
// Build option: MP64_SRAM_ARB_RR_EN selects round-robin instead of fixed priority.
module mp64_sram_arb
    import mp64_sram_arb_pkg::*;
#(
    parameter int ADDR_W  = 14,
    parameter int DATA_W  = 512,
    parameter int OUT_REG = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              rsp0_valid,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              sram_ce,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata
);
    localparam int LAT = arb_lat(OUT_REG);

    logic [1:0]       vld;
    logic [1:0]       gnt;
    tag_t             tag_d;
    tag_t [LAT-1:0]   pipe_q;

    // Gating the valids with reset keeps every command and ready output low during reset.
    assign vld = {req1_valid, req0_valid} & {2{rst_n}};

    mp64_rr_arb2 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid   (vld),
        .advance (|vld),
        .grant   (gnt)
    );

    assign req0_ready = gnt[0];
    assign req1_ready = gnt[1];
    assign sram_ce    = |gnt;
    assign sram_we    = gnt[0] ? req0_we : gnt[1] & req1_we;
    assign sram_addr  = gnt[0] ? req0_addr  : gnt[1] ? req1_addr  : '0;
    assign sram_wdata = gnt[0] ? req0_wdata : gnt[1] ? req1_wdata : '0;

    assign tag_d = '{valid: sram_ce & ~sram_we, id: gnt[1] ? REQ1 : REQ0};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pipe_q <= '0;
        end else begin
            pipe_q[0] <= tag_d;
            for (int i = 1; i < LAT; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign rsp0_valid = rst_n & pipe_q[LAT-1].valid & (pipe_q[LAT-1].id == REQ0);
    assign rsp1_valid = rst_n & pipe_q[LAT-1].valid & (pipe_q[LAT-1].id == REQ1);
    assign rsp_rdata  = sram_rdata;
endmodule
